// File: rtl/ysyx_23060191_wbu_q_if.sv
// Bundle of handshake, write-port, commit and forwarding signals for the write-back retire queue.
// The slave side is the queue itself; the master side is the LSU / register-file environment.
interface ysyx_23060191_wbu_q_if #(
    parameter int CPU_WIDTH = 32,
    parameter int REG_AW    = 5,
    parameter int CSR_AW    = 12
);
    logic                 i_valid;
    logic                 o_ready;
    logic [CPU_WIDTH-1:0] i_exu_res;
    logic [CPU_WIDTH-1:0] i_lsu_res;
    logic                 i_load_en;
    logic                 i_rd_wen;
    logic [REG_AW-1:0]    i_rd_addr;
    logic                 i_csr_res_en;
    logic [CSR_AW-1:0]    i_csr_addr;
    logic [CPU_WIDTH-1:0] i_csr_res;
    logic [CPU_WIDTH-1:0] i_pc;
    logic                 i_wb_ready;
    logic                 o_rd_wen;
    logic [REG_AW-1:0]    o_rd_addr;
    logic [CPU_WIDTH-1:0] o_data_wr_Rd;
    logic                 o_wr_en_csr;
    logic [CSR_AW-1:0]    o_csr_addr;
    logic [CPU_WIDTH-1:0] o_data_wr_csr;
    logic                 o_commit_valid;
    logic [CPU_WIDTH-1:0] o_commit_pc;
    logic [REG_AW-1:0]    i_chk_addr;
    logic                 o_chk_hit;
    logic [CPU_WIDTH-1:0] o_chk_data;
    logic [63:0]          o_retire_cnt;

    modport slave (
        input  i_valid, i_exu_res, i_lsu_res, i_load_en, i_rd_wen, i_rd_addr,
               i_csr_res_en, i_csr_addr, i_csr_res, i_pc, i_wb_ready, i_chk_addr,
        output o_ready, o_rd_wen, o_rd_addr, o_data_wr_Rd, o_wr_en_csr, o_csr_addr,
               o_data_wr_csr, o_commit_valid, o_commit_pc, o_chk_hit, o_chk_data,
               o_retire_cnt
    );

    modport master (
        output i_valid, i_exu_res, i_lsu_res, i_load_en, i_rd_wen, i_rd_addr,
               i_csr_res_en, i_csr_addr, i_csr_res, i_pc, i_wb_ready, i_chk_addr,
        input  o_ready, o_rd_wen, o_rd_addr, o_data_wr_Rd, o_wr_en_csr, o_csr_addr,
               o_data_wr_csr, o_commit_valid, o_commit_pc, o_chk_hit, o_chk_data,
               o_retire_cnt
    );
endinterface

// File: rtl/ysyx_23060191_wbu_q.sv
// Write-back retire queue: buffers completed instructions, retires one per granted cycle
// to the GPR/CSR write ports, and offers a forwarding lookup over still-queued results.
module ysyx_23060191_wbu_q #(
    parameter int CPU_WIDTH = 32,
    parameter int REG_AW    = 5,
    parameter int CSR_AW    = 12,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    ysyx_23060191_wbu_q_if.slave   bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [63:0]   retire_cnt_q, retire_cnt_d;

    logic [CPU_WIDTH-1:0] rd_data_q  [DEPTH];
    logic                 rd_wen_q   [DEPTH];
    logic [REG_AW-1:0]    rd_addr_q  [DEPTH];
    logic                 csr_en_q   [DEPTH];
    logic [CSR_AW-1:0]    csr_addr_q [DEPTH];
    logic [CPU_WIDTH-1:0] csr_data_q [DEPTH];
    logic [CPU_WIDTH-1:0] pc_q       [DEPTH];

    logic empty, full, enq, deq;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign enq   = bus.i_valid & ~full;
    assign deq   = ~empty & bus.i_wb_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            retire_cnt_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Payload storage needs no reset: validity is defined purely by pointers and count.
    always_ff @(posedge clk) begin
        if (enq) begin
            rd_data_q[wr_ptr_q]  <= bus.i_load_en ? bus.i_lsu_res : bus.i_exu_res;
            rd_wen_q[wr_ptr_q]   <= bus.i_rd_wen & (bus.i_rd_addr != '0);
            rd_addr_q[wr_ptr_q]  <= bus.i_rd_addr;
            csr_en_q[wr_ptr_q]   <= bus.i_csr_res_en;
            csr_addr_q[wr_ptr_q] <= bus.i_csr_addr;
            csr_data_q[wr_ptr_q] <= bus.i_csr_res;
            pc_q[wr_ptr_q]       <= bus.i_pc;
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        retire_cnt_d = retire_cnt_q;
        if (enq) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (deq) begin
            rd_ptr_d     = rd_ptr_q + PW'(1);
            retire_cnt_d = retire_cnt_q + 64'd1;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Walk oldest to youngest so the last match (youngest producer) wins; rd 0 never has wen set.
    logic                 chk_hit;
    logic [CPU_WIDTH-1:0] chk_data;
    logic [PW-1:0]        chk_idx;

    always_comb begin
        chk_hit  = 1'b0;
        chk_data = '0;
        chk_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            chk_idx = rd_ptr_q + PW'(k);
            if ((CW'(k) < count_q) && rd_wen_q[chk_idx] &&
                (rd_addr_q[chk_idx] == bus.i_chk_addr)) begin
                chk_hit  = 1'b1;
                chk_data = rd_data_q[chk_idx];
            end
        end
    end

    assign bus.o_ready        = ~full;
    assign bus.o_commit_valid = deq;
    assign bus.o_rd_wen       = deq & rd_wen_q[rd_ptr_q];
    assign bus.o_wr_en_csr    = deq & csr_en_q[rd_ptr_q];
    assign bus.o_rd_addr      = empty ? '0 : rd_addr_q[rd_ptr_q];
    assign bus.o_data_wr_Rd   = empty ? '0 : rd_data_q[rd_ptr_q];
    assign bus.o_csr_addr     = empty ? '0 : csr_addr_q[rd_ptr_q];
    assign bus.o_data_wr_csr  = empty ? '0 : csr_data_q[rd_ptr_q];
    assign bus.o_commit_pc    = empty ? '0 : pc_q[rd_ptr_q];
    assign bus.o_chk_hit      = chk_hit;
    assign bus.o_chk_data     = chk_data;
    assign bus.o_retire_cnt   = retire_cnt_q;
endmodule

// File: doc/ysyx_23060191_wbu_q.md
# ysyx_23060191_wbu_q

Parametrised write-back stage with a DEPTH-entry retire queue between LSU and the register file/CSR file. Accepts completed instructions over a valid/ready handshake, selects the Rd write data (load vs. ALU result), and retires one instruction per cycle when the write port grants. Also provides a combinational forwarding lookup over queued results and a 64-bit retired-instruction counter. Sits after the LSU; drives the GPR and CSR write ports.

## Interface
- CPU_WIDTH, 32, data width of all results
- REG_AW, 5, GPR address width
- CSR_AW, 12, CSR address width
- DEPTH, 4, queue entries; power of two, ≥2

- clk  in  1  clock; all state on rising edge
- rst  in  1  reset; asynchronous, active-high
- i_valid  in  1  upstream instruction valid
- o_ready  out  1  queue can accept (= !full)
- i_exu_res  in  CPU_WIDTH  EXU result
- i_lsu_res  in  CPU_WIDTH  load data
- i_load_en  in  1  1: Rd data = i_lsu_res, else i_exu_res
- i_rd_wen  in  1  instruction writes Rd
- i_rd_addr  in  REG_AW  Rd index
- i_csr_res_en  in  1  instruction writes a CSR
- i_csr_addr  in  CSR_AW  CSR index
- i_csr_res  in  CPU_WIDTH  CSR write data
- i_pc  in  CPU_WIDTH  instruction PC
- i_wb_ready  in  1  write ports available this cycle
- o_rd_wen  out  1  GPR write strobe
- o_rd_addr  out  REG_AW  GPR write index
- o_data_wr_Rd  out  CPU_WIDTH  GPR write data
- o_wr_en_csr  out  1  CSR write strobe
- o_csr_addr  out  CSR_AW  CSR write index
- o_data_wr_csr  out  CPU_WIDTH  CSR write data
- o_commit_valid  out  1  one instruction retires this cycle
- o_commit_pc  out  CPU_WIDTH  PC of retiring instruction
- i_chk_addr  in  REG_AW  forwarding lookup index
- o_chk_hit  out  1  queued entry will write i_chk_addr
- o_chk_data  out  CPU_WIDTH  data of youngest matching entry
- o_retire_cnt  out  64  retired-instruction count

## Operation
- Enqueue (enq = i_valid & o_ready): store {rd_data, rd_wen', rd_addr, csr_en, csr_addr, csr_data, pc} at wr_ptr; rd_data = i_load_en ? i_lsu_res : i_exu_res; rd_wen' = i_rd_wen & (i_rd_addr != 0).
- State: wr_ptr, rd_ptr (log2 DEPTH bits, wrap modulo DEPTH), count (0..DEPTH).
- Retire (deq = !empty & i_wb_ready): o_commit_valid=1, o_rd_wen = head.rd_wen', o_wr_en_csr = head.csr_en; rd_ptr advances, o_retire_cnt += 1 (wraps at 2^64).
- When !deq: o_commit_valid, o_rd_wen, o_wr_en_csr = 0. When empty: all data/address outputs = 0; otherwise they show head fields.
- o_ready = (count != DEPTH); no dependence on i_wb_ready (no same-cycle bypass when full).
- Forwarding: o_chk_hit = any valid entry with rd_wen' and rd_addr == i_chk_addr; o_chk_data from youngest such entry, else 0. i_chk_addr = 0 never hits. The entry retiring this cycle is still searched.

## Timing
- Reset: pointers, count, o_retire_cnt = 0; all outputs 0 except o_ready = 1 (DEPTH ≥ 1).
- Latency: instruction enqueued at edge k may retire in cycle after edge k (earliest write at edge k+1); no input-to-write combinational path.
- Simultaneous enq & deq: count unchanged, both pointers advance; allowed in any non-full, non-empty state; when empty only enq; when full only deq.
- Full: i_valid ignored, o_ready = 0 until a deq edge.
- i_wb_ready low: head held, outputs stable, strobes 0.
- Reset asserted mid-operation: queue emptied immediately (asynchronous), queued entries discarded, no strobes.

## Test plan
- Reset then enqueue {load_en=0, exu=0x11, rd=5, rd_wen=1}, i_wb_ready=1 -> next cycle o_rd_wen=1, o_rd_addr=5, o_data_wr_Rd=0x11, o_retire_cnt=1 after edge.
- Enqueue load_en=1, lsu=0xDEAD, exu=0x1; then rd=0 with rd_wen=1 -> first writes 0xDEAD; second commits with o_rd_wen=0.
- i_wb_ready=0, enqueue 4 with DEPTH=4 -> o_ready=0 after 4th; 5th i_valid ignored; raise ready -> 4 in-order retires, PCs 0x0,0x4,0x8,0xC.
- Queue entries rd=7 data 0xA then 0xB, i_chk_addr=7 -> o_chk_hit=1, o_chk_data=0xB; i_chk_addr=0 -> hit=0.
- CSR entry {csr_en=1, addr=0x341, data=0x80000010} -> o_wr_en_csr=1 with those values in retire cycle only.
- Assert rst with 3 entries queued -> o_commit_valid=0, o_ready=1, count 0, o_retire_cnt=0 immediately.
